// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared opcode/funct constants, FSM state and select encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_REG    = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_DM  = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_EXT = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic       ALUB_REG = 1'b0;
    localparam logic       ALUB_EXT = 1'b1;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_ADDU = 4'd0,
        CL_SUBU = 4'd1,
        CL_JR   = 4'd2,
        CL_ORI  = 4'd3,
        CL_LW   = 4'd4,
        CL_SW   = 4'd5,
        CL_BEQ  = 4'd6,
        CL_LUI  = 4'd7,
        CL_J    = 4'd8,
        CL_JAL  = 4'd9,
        CL_NONE = 4'd10
    } instr_class_t;

    // Classes that pass through EX into the data-memory stage.
    function automatic logic is_mem_class(input instr_class_t c);
        return (c == CL_LW) || (c == CL_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module : multicycle_ctrl_if
// Brief  : Controller <-> datapath bundle: IR fields, flags and control lines.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_we;
    logic             ir_we;
    logic             rf_we;
    logic             dm_we;
    logic [1:0]       npc_sel;
    logic [1:0]       mux4_32sel;
    logic [1:0]       mux4_5sel;
    logic             mux2sel;
    logic [1:0]       ext_op;
    logic [1:0]       aluop;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_we, ir_we, rf_we, dm_we, npc_sel, mux4_32sel, mux4_5sel,
               mux2sel, ext_op, aluop, illegal, instr_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_we, ir_we, rf_we, dm_we, npc_sel, mux4_32sel, mux4_5sel,
               mux2sel, ext_op, aluop, illegal, instr_cnt
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// Module : ctrl_decode
// Brief  : Combinational classification of opcode/funct into an instruction class.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t iclass,
    output logic         illegal
);

    always_comb begin
        iclass = CL_NONE;
        case (opcode)
            OP_RTYPE: begin
                // Only three funct codes are implemented; any other R-type traps.
                case (funct)
                    FN_ADDU: iclass = CL_ADDU;
                    FN_SUBU: iclass = CL_SUBU;
                    FN_JR:   iclass = CL_JR;
                    default: iclass = CL_NONE;
                endcase
            end
            OP_ORI:  iclass = CL_ORI;
            OP_LW:   iclass = CL_LW;
            OP_SW:   iclass = CL_SW;
            OP_BEQ:  iclass = CL_BEQ;
            OP_LUI:  iclass = CL_LUI;
            OP_J:    iclass = CL_J;
            OP_JAL:  iclass = CL_JAL;
            default: iclass = CL_NONE;
        endcase
    end

    assign illegal = (iclass == CL_NONE);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : IF/ID/EX/MEM/WB control FSM for a multicycle MIPS subset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_t           state;
    state_t           next_state;
    instr_class_t     iclass;
    logic             dec_illegal;
    logic [CNT_W-1:0] instr_cnt;

    logic       w_pc_we, w_ir_we, w_rf_we, w_dm_we;
    logic [1:0] w_npc_sel, w_mux4_32sel, w_mux4_5sel, w_ext_op, w_aluop;
    logic       w_mux2sel, w_illegal;

    ctrl_decode u_decode (
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .iclass  (iclass),
        .illegal (dec_illegal)
    );

    always_comb begin
        w_pc_we      = 1'b0;
        w_ir_we      = 1'b0;
        w_rf_we      = 1'b0;
        w_dm_we      = 1'b0;
        w_npc_sel    = NPC_PC4;
        w_mux4_32sel = WB_ALU;
        w_mux4_5sel  = DST_RT;
        w_mux2sel    = ALUB_REG;
        w_ext_op     = EXT_ZERO;
        w_aluop      = ALU_ADD;
        w_illegal    = 1'b0;
        next_state   = state;
        case (state)
            ST_IF: begin
                w_ir_we    = 1'b1;
                w_pc_we    = 1'b1;
                w_npc_sel  = NPC_PC4;
                next_state = ST_ID;
            end
            ST_ID: begin
                case (iclass)
                    CL_J: begin
                        w_pc_we    = 1'b1;
                        w_npc_sel  = NPC_JUMP;
                        next_state = ST_IF;
                    end
                    CL_JR: begin
                        w_pc_we    = 1'b1;
                        w_npc_sel  = NPC_REG;
                        next_state = ST_IF;
                    end
                    CL_JAL: begin
                        // PC already holds PC+4 from IF; WB links that value.
                        w_pc_we    = 1'b1;
                        w_npc_sel  = NPC_JUMP;
                        next_state = ST_WB;
                    end
                    CL_NONE: begin
                        w_illegal  = dec_illegal;
                        next_state = ST_IF;
                    end
                    default: next_state = ST_EX;
                endcase
            end
            ST_EX: begin
                case (iclass)
                    CL_ADDU: begin
                        w_mux2sel  = ALUB_REG;
                        w_aluop    = ALU_ADD;
                        next_state = ST_WB;
                    end
                    CL_SUBU: begin
                        w_mux2sel  = ALUB_REG;
                        w_aluop    = ALU_SUB;
                        next_state = ST_WB;
                    end
                    CL_ORI: begin
                        w_mux2sel  = ALUB_EXT;
                        w_ext_op   = EXT_ZERO;
                        w_aluop    = ALU_OR;
                        next_state = ST_WB;
                    end
                    CL_LW, CL_SW: begin
                        w_mux2sel  = ALUB_EXT;
                        w_ext_op   = EXT_SIGN;
                        w_aluop    = ALU_ADD;
                        next_state = ST_MEM;
                    end
                    CL_BEQ: begin
                        w_aluop    = ALU_SUB;
                        w_pc_we    = bus.zero;
                        w_npc_sel  = NPC_BRANCH;
                        next_state = ST_IF;
                    end
                    CL_LUI:  next_state = ST_WB;
                    default: next_state = ST_IF;
                endcase
            end
            ST_MEM: begin
                w_dm_we = (iclass == CL_SW);
                if (bus.mem_ready || !is_mem_class(iclass)) begin
                    next_state = (iclass == CL_LW) ? ST_WB : ST_IF;
                end
            end
            ST_WB: begin
                w_rf_we = 1'b1;
                case (iclass)
                    CL_ADDU, CL_SUBU: begin
                        w_mux4_5sel  = DST_RD;
                        w_mux4_32sel = WB_ALU;
                    end
                    CL_LW:  w_mux4_32sel = WB_DM;
                    CL_LUI: begin
                        w_mux4_32sel = WB_EXT;
                        w_ext_op     = EXT_LUI;
                    end
                    CL_JAL: begin
                        w_mux4_5sel  = DST_RA;
                        w_mux4_32sel = WB_PC4;
                    end
                    default: w_mux4_32sel = WB_ALU;
                endcase
                next_state = ST_IF;
            end
            default: next_state = ST_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IF;
            instr_cnt <= '0;
        end else begin
            state <= next_state;
            // An instruction retires when the FSM wraps back to IF, unless it trapped.
            if (state != ST_IF && next_state == ST_IF && !w_illegal) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

    // Reset gates the outputs directly so enables drop without waiting for a clock.
    assign bus.pc_we      = rst_n & w_pc_we;
    assign bus.ir_we      = rst_n & w_ir_we;
    assign bus.rf_we      = rst_n & w_rf_we;
    assign bus.dm_we      = rst_n & w_dm_we;
    assign bus.npc_sel    = rst_n ? w_npc_sel    : 2'b00;
    assign bus.mux4_32sel = rst_n ? w_mux4_32sel : 2'b00;
    assign bus.mux4_5sel  = rst_n ? w_mux4_5sel  : 2'b00;
    assign bus.mux2sel    = rst_n & w_mux2sel;
    assign bus.ext_op     = rst_n ? w_ext_op     : 2'b00;
    assign bus.aluop      = rst_n ? w_aluop      : 2'b00;
    assign bus.illegal    = rst_n & w_illegal;
    assign bus.instr_cnt  = instr_cnt;

endmodule

`default_nettype wire
